// File: rtl/switch_capture_if.sv
// Board/CPU side bundle of the switch capture stage: raw pads in, IO read bus out.
// No storage; pure signal grouping.
// No flow control: the CPU read strobe is a single-cycle access.
interface switch_capture_if;
  logic [15:0] switchInput;
  logic        confirmBtn;
  logic [31:0] address;
  logic        ioRead;
  logic [15:0] dataIOInput;
  logic        valid;
  logic        overrun;

  // Board pads and CPU drive the inputs, observe read data and flags
  modport master (
    output switchInput, confirmBtn, address, ioRead,
    input  dataIOInput, valid, overrun
  );

  // The capture block consumes pads/bus and returns read data and flags
  modport slave (
    input  switchInput, confirmBtn, address, ioRead,
    output dataIOInput, valid, overrun
  );
endinterface

// File: rtl/switch_capture.sv
// Syncs switches/button, debounces the button, snapshots switches once per confirmed press.
// Latency: capture 2 + DEBOUNCE_CYCLES cycles after a clean button rise; read data combinational.
// No backpressure: an unread snapshot is overwritten and flagged as overrun.
module switch_capture #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1_000_000,
  parameter int          CNT_W           = 20,
  parameter logic [31:0] DATA_ADDR       = 32'hffff_fff4,
  parameter logic [31:0] STAT_ADDR       = 32'hffff_fff8
) (
  input  logic            clk,
  input  logic            rst,
  switch_capture_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 20'd1);

  logic             btn_s1, btn_s;
  logic [15:0]      sw_s1, sw_s;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic             capture;
  logic [15:0]      snapshot;
  logic             valid, overrun;
  logic             data_rd, stat_rd;

  // Two-flop synchronisers; only the second stage feeds any logic
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_s1 <= 1'b0;
      btn_s  <= 1'b0;
      sw_s1  <= '0;
      sw_s   <= '0;
    end else begin
      btn_s1 <= bus.confirmBtn;
      btn_s  <= btn_s1;
      sw_s1  <= bus.switchInput;
      sw_s   <= sw_s1;
    end
  end

  // Debounce counter never wraps past its terminal value
  assign cnt_inc = (cnt == CNT_LAST) ? cnt : cnt + 1'b1;

  // Debounce state and counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: a level is accepted on the edge where the counter
  // steps onto its terminal value, so the IDLE cycle that first saw the new
  // level counts as one of the stable cycles.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (btn_s) state_nxt = PRESS_DB;
      end
      PRESS_DB: begin
        if (!btn_s) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else if (cnt_inc == CNT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = HELD;
          capture   = 1'b1;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      HELD: begin
        cnt_nxt = '0;
        if (!btn_s) state_nxt = RELEASE_DB;
      end
      RELEASE_DB: begin
        if (btn_s) begin
          cnt_nxt   = '0;
          state_nxt = HELD;
        end else if (cnt_inc == CNT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  assign data_rd = bus.ioRead && (bus.address == DATA_ADDR);
  assign stat_rd = bus.ioRead && (bus.address == STAT_ADDR);

  // Snapshot and flags; a capture takes priority over a clearing read on the same edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snapshot <= '0;
      valid    <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (capture) begin
        snapshot <= sw_s;
        valid    <= 1'b1;
      end else if (data_rd) begin
        valid <= 1'b0;
      end
      if (capture && valid) overrun <= 1'b1;
      else if (stat_rd)     overrun <= 1'b0;
    end
  end

  // Read mux is purely address-decoded; the strobe only drives clear-on-read
  always_comb begin
    bus.dataIOInput = 16'h0000;
    if (bus.address == DATA_ADDR)      bus.dataIOInput = snapshot;
    else if (bus.address == STAT_ADDR) bus.dataIOInput = {14'b0, overrun, valid};
  end

  assign bus.valid   = valid;
  assign bus.overrun = overrun;

endmodule

// File: tb/tb_switch_capture.sv
// Directed bench for switch_capture with a short debounce window.
// Table-driven read-mux/clear vectors plus hand-written press sequences.
// Inputs driven #1 after posedge, outputs sampled before the next edge.
module tb_switch_capture;

  localparam logic [31:0] DA = 32'hffff_fff4;
  localparam logic [31:0] SA = 32'hffff_fff8;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  switch_capture_if bus();

  switch_capture #(
    .DEBOUNCE_CYCLES(20'd4),
    .CNT_W          (20),
    .DATA_ADDR      (DA),
    .STAT_ADDR      (SA)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        rd;
    logic [15:0] data;
    logic        vld;
    logic        ovr;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Combinational read check without a strobe
  task automatic rd_peek(input string name, input logic [31:0] a, input logic [15:0] exp);
    bus.address = a;
    #1;
    check(name, 32'(bus.dataIOInput), 32'(exp));
  endtask

  // Read with strobe: checks data then clocks the access
  task automatic rd_clr(input string name, input logic [31:0] a, input logic [15:0] exp);
    bus.address = a;
    bus.ioRead  = 1'b1;
    #1;
    check(name, 32'(bus.dataIOInput), 32'(exp));
    tick();
    bus.ioRead = 1'b0;
  endtask

  task automatic press(input logic [15:0] sw);
    bus.switchInput = sw;
    bus.confirmBtn  = 1'b1;
    repeat (10) tick();
    bus.confirmBtn  = 1'b0;
    repeat (10) tick();
  endtask

  // Raise the button and count edges until valid, bounded
  task automatic press_latency(input logic [15:0] sw, output int n);
    n = 0;
    bus.switchInput = sw;
    bus.confirmBtn  = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (bus.valid && n == 0) n = c;
    end
    bus.confirmBtn = 1'b0;
    repeat (10) tick();
  endtask

  initial begin
    int  n;
    logic early;
    total = 0;
    bad   = 0;

    // Reads/clears starting from valid=1, overrun=1, snapshot=2222
    vecs[0] = '{32'hffff_fff0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[1] = '{DA,            1'b0, 16'h2222, 1'b1, 1'b1};
    vecs[2] = '{SA,            1'b0, 16'h0003, 1'b1, 1'b1};
    vecs[3] = '{32'hffff_fffc, 1'b1, 16'h0000, 1'b1, 1'b1};
    vecs[4] = '{SA,            1'b1, 16'h0003, 1'b1, 1'b0};
    vecs[5] = '{SA,            1'b0, 16'h0001, 1'b1, 1'b0};
    vecs[6] = '{DA,            1'b1, 16'h2222, 1'b0, 1'b0};
    vecs[7] = '{SA,            1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[8] = '{DA,            1'b0, 16'h2222, 1'b0, 1'b0};
    vecs[9] = '{32'h0000_fff4, 1'b0, 16'h0000, 1'b0, 1'b0};

    rst             = 1'b0;
    bus.switchInput = '0;
    bus.confirmBtn  = 1'b0;
    bus.address     = '0;
    bus.ioRead      = 1'b0;

    // Reset state
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("reset_valid",   32'(bus.valid),   32'd0);
    check("reset_overrun", 32'(bus.overrun), 32'd0);
    rd_peek("reset_data", DA, 16'h0000);
    rd_peek("reset_stat", SA, 16'h0000);

    // Clean press: valid exactly 6 edges after the button rise
    bus.switchInput = 16'hA5C3;
    bus.confirmBtn  = 1'b1;
    repeat (5) tick();
    check("clean_not_yet", 32'(bus.valid), 32'd0);
    tick();
    check("clean_rise6", 32'(bus.valid), 32'd1);
    repeat (4) tick();
    bus.confirmBtn = 1'b0;
    repeat (10) tick();
    rd_clr("clean_data", DA, 16'hA5C3);
    check("clean_cleared", 32'(bus.valid), 32'd0);

    // Bounce: three short pulses never capture
    bus.switchInput = 16'h5A5A;
    early = 1'b0;
    for (int p = 0; p < 3; p++) begin
      bus.confirmBtn = 1'b1;
      tick(); if (bus.valid) early = 1'b1;
      tick(); if (bus.valid) early = 1'b1;
      bus.confirmBtn = 1'b0;
      tick(); if (bus.valid) early = 1'b1;
    end
    check("bounce_no_capture", 32'(early), 32'd0);
    press_latency(16'h5A5A, n);
    check("bounce_latency", 32'(n), 32'd6);
    rd_clr("bounce_data", DA, 16'h5A5A);
    rd_peek("bounce_stat", SA, 16'h0000);

    // Long hold with changing switches: single capture
    bus.switchInput = 16'h0001;
    bus.confirmBtn  = 1'b1;
    repeat (10) tick();
    check("hold_first", 32'(bus.valid), 32'd1);
    rd_clr("hold_data1", DA, 16'h0001);
    bus.switchInput = 16'h0002;
    repeat (50) tick();
    check("hold_no_recapture", 32'(bus.valid), 32'd0);
    rd_peek("hold_snapshot", DA, 16'h0001);
    bus.confirmBtn = 1'b0;
    repeat (10) tick();
    check("release_no_capture", 32'(bus.valid), 32'd0);
    press(16'h0002);
    check("repress_valid", 32'(bus.valid), 32'd1);
    rd_clr("repress_data", DA, 16'h0002);

    // Overrun: two presses without reading, then the read-mux table
    press(16'h1111);
    press(16'h2222);
    for (int i = 0; i < 10; i++) begin
      bus.address = vecs[i].addr;
      bus.ioRead  = vecs[i].rd;
      #1;
      check($sformatf("vec%0d_data", i), 32'(bus.dataIOInput), 32'(vecs[i].data));
      tick();
      bus.ioRead = 1'b0;
      check($sformatf("vec%0d_valid", i),   32'(bus.valid),   32'(vecs[i].vld));
      check($sformatf("vec%0d_overrun", i), 32'(bus.overrun), 32'(vecs[i].ovr));
    end

    // DATA read on the capture edge returns the old snapshot, valid stays set
    bus.switchInput = 16'h3333;
    bus.confirmBtn  = 1'b1;
    repeat (5) tick();
    check("race_pre_valid", 32'(bus.valid), 32'd0);
    bus.address = DA;
    bus.ioRead  = 1'b1;
    #1;
    check("race_old_data", 32'(bus.dataIOInput), 32'h2222);
    tick();
    bus.ioRead = 1'b0;
    check("race_valid_kept", 32'(bus.valid), 32'd1);
    rd_peek("race_new_data", DA, 16'h3333);
    bus.confirmBtn = 1'b0;
    repeat (10) tick();

    // Asynchronous reset in the middle of a press discards it
    bus.switchInput = 16'h4444;
    bus.confirmBtn  = 1'b1;
    repeat (4) tick();
    rst = 1'b0;
    #1;
    check("midrst_valid_async", 32'(bus.valid), 32'd0);
    rd_peek("midrst_data", DA, 16'h0000);
    bus.confirmBtn = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    repeat (10) tick();
    check("midrst_no_capture", 32'(bus.valid), 32'd0);
    press_latency(16'h6789, n);
    check("post_rst_latency", 32'(n), 32'd6);
    rd_clr("post_rst_data", DA, 16'h6789);
    rd_peek("post_rst_stat", SA, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
